// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte-path blocks.
// The feeder's optional resend behaviour is selected with the UART_TX_RETRY_EN macro.
package uart_pkg;

    localparam int UART_BYTE_W  = 8;
    localparam int TX_MAX_RETRY = 3;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RETRY
    } tx_feed_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered occupancy count.
// Shared by the TX feeder and the RX side.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      level_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = level_q;

    // NOTE: the storage array is deliberately not reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding uart_top's transmitter; counts errored bytes.
// Define UART_TX_RETRY_EN to resend a failed byte up to TX_MAX_RETRY extra times.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int START_HOLD = 32,
    parameter int TIMEOUT    = 1 << 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [UART_BYTE_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   tx_start,
    output logic [UART_BYTE_W-1:0] tx_data,
    input  logic                   tx_done,
    input  logic                   tx_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             err_cnt
);

    localparam int HW = $clog2(START_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    tx_feed_state_e         state_q;
    logic                   tx_start_q;
    logic [UART_BYTE_W-1:0] tx_data_q;
    logic [HW-1:0]          hold_q;
    logic [TW-1:0]          to_q;
    logic                   done_pend_q;
    logic                   err_pend_q;
    logic [7:0]             err_cnt_q;
    logic [2:0]             done_sync_q;
    logic [2:0]             err_sync_q;
`ifdef UART_TX_RETRY_EN
    logic [1:0]             retry_q;
`endif

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [UART_BYTE_W-1:0] fifo_rdata;
    logic                   done_rise;
    logic                   err_rise;
    logic                   done_evt;
    logic                   fail;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .wdata_i (in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign in_ready = !fifo_full;
    assign fifo_pop = (state_q == IDLE) && !fifo_empty;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign err_cnt  = err_cnt_q;

    // Bit 1 is the synchronised level; bit 2 is its previous value for edge detection.
    assign done_rise = done_sync_q[1] && !done_sync_q[2];
    assign err_rise  = err_sync_q[1] && !err_sync_q[2];

    // Edges seen during LAUNCH are held in the pend flags and count as if they arrived now.
    // A done that coincides with a raised err is an error; a timeout only loses to a clean done.
    assign done_evt = done_rise || done_pend_q;
    assign fail     = err_rise || err_pend_q || (done_evt && err_sync_q[1])
                   || (!done_evt && (to_q == TW'(TIMEOUT - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            hold_q      <= '0;
            to_q        <= '0;
            done_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
            err_cnt_q   <= '0;
            done_sync_q <= '0;
            err_sync_q  <= '0;
`ifdef UART_TX_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            done_sync_q <= {done_sync_q[1:0], tx_done};
            err_sync_q  <= {err_sync_q[1:0], tx_err};

            unique case (state_q)
                IDLE: begin
                    done_pend_q <= 1'b0;
                    err_pend_q  <= 1'b0;
                    if (!fifo_empty) begin
                        tx_data_q  <= fifo_rdata;
                        tx_start_q <= 1'b1;
                        hold_q     <= '0;
                        state_q    <= LAUNCH;
`ifdef UART_TX_RETRY_EN
                        retry_q    <= '0;
`endif
                    end
                end

                LAUNCH: begin
                    if (done_rise) done_pend_q <= 1'b1;
                    if (err_rise)  err_pend_q  <= 1'b1;
                    if (hold_q == HW'(START_HOLD - 1)) begin
                        tx_start_q <= 1'b0;
                        to_q       <= '0;
                        state_q    <= WAIT;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end

                WAIT: begin
                    done_pend_q <= 1'b0;
                    err_pend_q  <= 1'b0;
                    if (fail) begin
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
`ifdef UART_TX_RETRY_EN
                        state_q <= (retry_q < 2'(TX_MAX_RETRY)) ? RETRY : IDLE;
`else
                        state_q <= IDLE;
`endif
                    end else if (done_evt) begin
                        state_q <= IDLE;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                end

`ifdef UART_TX_RETRY_EN
                RETRY: begin
                    tx_start_q <= 1'b1;
                    hold_q     <= '0;
                    retry_q    <= retry_q + 2'd1;
                    state_q    <= LAUNCH;
                end
`endif

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
